// File: rtl/mmio_responder_pkg.sv
// rtl/mmio_responder_pkg.sv - MMIO register offsets, store/load size encodings and load extension helper
package mmio_responder_pkg;

   // Register offsets within the 256-byte window (word aligned)
   localparam logic [7:0] MMIO_STATUS = 8'h00;
   localparam logic [7:0] MMIO_RXDATA = 8'h04;
   localparam logic [7:0] MMIO_TXDATA = 8'h08;
   localparam logic [7:0] MMIO_CYCLE  = 8'h10;
   localparam logic [7:0] MMIO_INSTR  = 8'h14;
   localparam logic [7:0] MMIO_CNTCLR = 8'h18;
   localparam logic [7:0] MMIO_TXDROP = 8'h1C;

   // Store sizes as issued by the pipeline controller
   localparam logic [1:0] ST_SIZE_B = 2'd0;
   localparam logic [1:0] ST_SIZE_H = 2'd1;
   localparam logic [1:0] ST_SIZE_W = 2'd2;

   // Load function codes (funct3 of the load instruction)
   typedef enum logic [2:0] {
      FNC_LB  = 3'b000,
      FNC_LH  = 3'b001,
      FNC_LW  = 3'b010,
      FNC_LBU = 3'b100,
      FNC_LHU = 3'b101
   } ld_fnc_e;

   // Select the addressed byte/half of a register word and extend it; unknown codes act as LW
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  boff,
                                               input logic [2:0]  fnc);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {boff, 3'b000});
      h = boff[1] ? word[31:16] : word[15:0];
      case (fnc)
         FNC_LB:  return {{24{b[7]}}, b};
         FNC_LH:  return {{16{h[15]}}, h};
         FNC_LBU: return {24'd0, b};
         FNC_LHU: return {16'd0, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/mmio_responder_tx_fifo.sv
// rtl/mmio_responder_tx_fifo.sv - TX byte FIFO toward the UART (module mmio_tx_fifo)
module mmio_tx_fifo #(
   parameter int TX_DEPTH = 4,
   parameter int TX_AW    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] head_data
);
   localparam int CW = TX_AW + 1;

   logic [7:0]       mem_q [TX_DEPTH];
   logic [7:0]       mem_d [TX_DEPTH];
   logic [TX_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [TX_AW:0]   count_q, count_d;
   logic             do_push, do_pop;

   // Depth is a power of two, so the count reaches TX_DEPTH exactly when its top bit sets
   assign empty     = (count_q == '0);
   assign full      = count_q[TX_AW];
   assign do_pop    = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign do_push   = push && (!full || do_pop);
   assign head_data = empty ? 8'h00 : mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + TX_AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + TX_AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards all queued bytes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - MMIO window responder: registers, TX FIFO, RX handoff, counters (option MMIO_TX_DROP_CNT_EN)
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
   parameter int          TX_DEPTH  = 4,
   parameter int          TX_AW     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_st_size,
   input  logic [2:0]  req_ld_size,
   input  logic        inst_retired,
   output logic        rsp_valid,
   output logic        rsp_hit,
   output logic [31:0] rsp_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready
);
   logic        acc_hit, ld_hit, st_hit;
   logic [7:0]  reg_off;
   logic        tx_push, tx_pop, cnt_clr;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic [31:0] rd_word;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rx_ready_q, rx_ready_d;
   logic [31:0] cycle_q, cycle_d, instr_q, instr_d;
   logic        unused_inputs;

   // Store size never matters here: TXDATA takes the low byte, CNTCLR any access
   assign unused_inputs = ^{req_wdata[31:8], req_st_size};

   // Registers are decoded per word; addr[1:0] only picks the byte/half lane
   assign acc_hit = req_valid && (req_addr[31:8] == MMIO_BASE[31:8]);
   assign ld_hit  = acc_hit && !req_we;
   assign st_hit  = acc_hit && req_we;
   assign reg_off = {req_addr[7:2], 2'b00};
   assign tx_push = st_hit && (reg_off == MMIO_TXDATA);
   assign cnt_clr = st_hit && (reg_off == MMIO_CNTCLR);
   assign tx_pop  = !fifo_empty && tx_ready;

   mmio_tx_fifo #(
      .TX_DEPTH (TX_DEPTH),
      .TX_AW    (TX_AW)
   ) u_tx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (tx_push),
      .push_data (req_wdata[7:0]),
      .pop       (tx_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (fifo_head)
   );

   assign tx_valid  = !fifo_empty;
   assign tx_data   = fifo_head;
   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rx_ready  = rx_ready_q;

`ifdef MMIO_TX_DROP_CNT_EN
   logic [31:0] drop_q, drop_d;

   // Count pushes lost to a full FIFO, saturating; cleared with the other counters
   always_comb begin
      drop_d = drop_q;
      if (cnt_clr) begin
         drop_d = '0;
      end else if (tx_push && fifo_full && !tx_pop && (drop_q != 32'hFFFF_FFFF)) begin
         drop_d = drop_q + 32'd1;
      end
   end

   // Drop counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) drop_q <= '0;
      else          drop_q <= drop_d;
   end
`endif

   // Read mux: value of the addressed register as seen at the load edge
   always_comb begin
      rd_word = '0;
      case (reg_off)
         MMIO_STATUS: rd_word = {30'd0, rx_valid, !fifo_full};
         MMIO_RXDATA: rd_word = rx_valid ? {24'd0, rx_data} : 32'd0;
         MMIO_CYCLE:  rd_word = cycle_q;
         MMIO_INSTR:  rd_word = instr_q;
`ifdef MMIO_TX_DROP_CNT_EN
         MMIO_TXDROP: rd_word = drop_q;
`endif
         default:     rd_word = '0;
      endcase
   end

   // Response, RX pop pulse and counter next-state; a clear beats the increment
   always_comb begin
      rsp_valid_d = ld_hit;
      rsp_rdata_d = ld_hit ? load_extend(rd_word, req_addr[1:0], req_ld_size) : 32'd0;
      rx_ready_d  = ld_hit && (reg_off == MMIO_RXDATA) && rx_valid;
      cycle_d     = cnt_clr ? 32'd0 : cycle_q + 32'd1;
      instr_d     = cnt_clr ? 32'd0 : instr_q + {31'd0, inst_retired};
   end

   // Response and counter registers; reset drops any in-flight response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rx_ready_q  <= 1'b0;
         cycle_q     <= '0;
         instr_q     <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rx_ready_q  <= rx_ready_d;
         cycle_q     <= cycle_d;
         instr_q     <= instr_d;
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - self-checking bench for mmio_responder (honours MMIO_TX_DROP_CNT_EN)
module tb_mmio_responder;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_we, inst_retired, tx_ready, rx_valid;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_st_size;
   logic [2:0]  req_ld_size;
   logic [7:0]  rx_data;
   logic        rsp_valid, rsp_hit, rx_ready, tx_valid;
   logic [31:0] rsp_rdata;
   logic [7:0]  tx_data;

`ifdef MMIO_TX_DROP_CNT_EN
   localparam logic [31:0] EXP_DROP = 32'd1;
`else
   localparam logic [31:0] EXP_DROP = 32'd0;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0]  model_fifo[$];
   logic [31:0] mc = 0, mi = 0, md = 0;
   logic        exp_rsp_valid = 0, exp_rx_ready = 0;
   logic [31:0] exp_rdata = 0;
   logic [7:0]  got[$];

   mmio_responder dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_st_size  (req_st_size),
      .req_ld_size  (req_ld_size),
      .inst_retired (inst_retired),
      .rsp_valid    (rsp_valid),
      .rsp_hit      (rsp_hit),
      .rsp_rdata    (rsp_rdata),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (f)
         3'b000:  return (b > 127)   ? b - 32'd256   : b;
         3'b001:  return (h > 32767) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_reg(input int off);
      case (off)
         0:  return {30'd0, rx_valid, (model_fifo.size() < 4)};
         4:  return rx_valid ? {24'd0, rx_data} : 32'd0;
         16: return mc;
         20: return mi;
         28: begin
`ifdef MMIO_TX_DROP_CNT_EN
            return md;
`else
            return 32'd0;
`endif
         end
         default: return 32'd0;
      endcase
   endfunction

   // Reference model: advance on every clock edge, clear on reset
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (reset_n !== 1'b1) begin
         model_fifo.delete();
         mc = 0; mi = 0; md = 0;
         exp_rsp_valid = 0; exp_rx_ready = 0; exp_rdata = 0;
      end else begin
         bit hit, was_full, popping;
         int off;
         hit      = req_valid && (req_addr[31:8] == 24'h80_0000);
         off      = int'(req_addr[7:0]) & 32'hFC;
         was_full = (model_fifo.size() == 4);
         popping  = (model_fifo.size() > 0) && tx_ready;
         exp_rsp_valid = hit && !req_we;
         exp_rx_ready  = exp_rsp_valid && (off == 4) && rx_valid;
         if (exp_rsp_valid) exp_rdata = model_load(model_reg(off), req_addr[1:0], req_ld_size);
         if (popping) void'(model_fifo.pop_front());
         if (hit && req_we && off == 8) begin
            if (!was_full || popping) model_fifo.push_back(req_wdata[7:0]);
            else if (md != 32'hFFFF_FFFF) md = md + 1;
         end
         if (hit && req_we && off == 24) begin
            mc = 0; mi = 0; md = 0;
         end else begin
            mc = mc + 1;
            mi = mi + inst_retired;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      check("rsp_hit", rsp_hit, exp_rsp_valid);
      if (exp_rsp_valid) check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rx_ready", rx_ready, exp_rx_ready);
      check("tx_valid", tx_valid, model_fifo.size() != 0);
      if (model_fifo.size() != 0) check("tx_data", tx_data, model_fifo[0]);
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Caller is at a negedge; returns at the negedge where the response is visible
   task automatic do_load(input logic [31:0] a, input logic [2:0] f,
                          output logic [31:0] d, output logic v, output logic rr);
      req_valid = 1; req_we = 0; req_addr = a; req_ld_size = f;
      @(negedge clk);
      d = rsp_rdata; v = rsp_valid; rr = rx_ready;
      req_valid = 0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] w, input logic [1:0] s);
      req_valid = 1; req_we = 1; req_addr = a; req_wdata = w; req_st_size = s;
      @(negedge clk);
      req_valid = 0; req_we = 0;
   endtask

   task automatic drain(input int maxc);
      got.delete();
      tx_ready = 1;
      repeat (maxc) begin
         if (tx_valid) got.push_back(tx_data);
         @(negedge clk);
      end
      tx_ready = 0;
   endtask

   initial begin
      logic [31:0] d;
      logic        v, rr;
      reset_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      req_st_size = 0; req_ld_size = 0; inst_retired = 0; tx_ready = 0;
      rx_valid = 0; rx_data = 0;
      repeat (3) @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_hit", rsp_hit, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rx_ready", rx_ready, 0);
      check("reset_tx_valid", tx_valid, 0);
      check("reset_tx_data", tx_data, 0);
      reset_n = 1;

      // Counters
      repeat (10) @(negedge clk);
      do_load(32'h8000_0010, 3'b010, d, v, rr);
      check("cycle_after_10", d, 10);
      check("cycle_load_valid", v, 1);
      inst_retired = 1;
      repeat (3) @(negedge clk);
      inst_retired = 0;
      do_load(32'h8000_0014, 3'b010, d, v, rr);
      check("instr_3", d, 3);
      inst_retired = 1;
      do_store(32'h8000_0018, 32'h0, 2'd2);
      inst_retired = 0;
      do_load(32'h8000_0010, 3'b010, d, v, rr);
      check("cycle_cleared", d, 0);
      do_load(32'h8000_0014, 3'b010, d, v, rr);
      check("instr_cleared", d, 0);
      do_load(32'h8000_0010, 3'b010, d, v, rr);
      check("cycle_from_0", d, 2);

      // RX loads
      rx_valid = 1; rx_data = 8'hA5;
      do_load(32'h8000_0004, 3'b000, d, v, rr);
      check("rx_lb", d, 32'hFFFF_FFA5);
      check("rx_pop_pulse", rr, 1);
      @(negedge clk);
      check("rx_pop_single", rx_ready, 0);
      rx_valid = 0;
      do_load(32'h8000_0004, 3'b100, d, v, rr);
      check("rx_empty_lbu", d, 0);
      check("rx_empty_no_pulse", rr, 0);

      // TX full and drop
      for (int k = 0; k < 4; k++) do_store(32'h8000_0008, 32'h41 + k, 2'd0);
      do_load(32'h8000_0000, 3'b010, d, v, rr);
      check("status_full", d, 32'h0);
      do_store(32'h8000_0008, 32'h45, 2'd0);
      drain(8);
      check("tx_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got.size()) check("tx_order", got[k], 8'h41 + k);
      do_load(32'h8000_001C, 3'b010, d, v, rr);
      check("txdrop_after_drop", d, EXP_DROP);

      // Simultaneous push and pop while full
      for (int k = 0; k < 4; k++) do_store(32'h8000_0008, 32'h61 + k, 2'd2);
      tx_ready = 1;
      do_store(32'h8000_0008, 32'h55, 2'd1);
      tx_ready = 0;
      do_load(32'h8000_0000, 3'b010, d, v, rr);
      check("status_still_full", d, 32'h0);
      drain(8);
      check("simul_count", got.size(), 4);
      if (got.size() == 4) begin
         check("simul_b0", got[0], 8'h62);
         check("simul_b3", got[3], 8'h55);
      end
      do_load(32'h8000_001C, 3'b010, d, v, rr);
      check("txdrop_no_new_drop", d, EXP_DROP);

      // Window miss
      do_load(32'h1000_0010, 3'b010, d, v, rr);
      check("miss_load", v, 0);
      do_load(32'h8000_0110, 3'b010, d, v, rr);
      check("miss_load_adjacent", v, 0);
      do_store(32'h1000_0008, 32'h77, 2'd0);
      check("miss_store_fifo", tx_valid, 0);

      // Async reset with bytes queued and a load in flight
      for (int k = 0; k < 3; k++) do_store(32'h8000_0008, 32'h30 + k, 2'd0);
      req_valid = 1; req_we = 0; req_addr = 32'h8000_0000; req_ld_size = 3'b010;
      @(posedge clk);
      #1;
      check("inflight_rsp", rsp_valid, 1);
      check("inflight_tx", tx_valid, 1);
      reset_n = 0;
      #1;
      check("async_rsp_valid", rsp_valid, 0);
      check("async_tx_valid", tx_valid, 0);
      req_valid = 0;
      @(negedge clk);
      reset_n = 1;
      do_load(32'h8000_0000, 3'b010, d, v, rr);
      check("status_after_reset", d, 32'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [7:0]  off_w;
         logic [31:0] base;
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = ($urandom_range(0, 2) == 0);
         off_w     = 8'($urandom_range(0, 8) * 4);
         if (req_we && off_w == 8'h18 && $urandom_range(0, 7) != 0) off_w = 8'h08;
         case ($urandom_range(0, 9))
            0:       base = 32'h1000_0000;
            1:       base = 32'h8000_0100;
            default: base = 32'h8000_0000;
         endcase
         req_addr     = base | {24'd0, off_w} | 32'($urandom_range(0, 3));
         req_wdata    = $urandom;
         req_st_size  = 2'($urandom_range(0, 2));
         req_ld_size  = 3'($urandom_range(0, 7));
         inst_retired = 1'($urandom_range(0, 1));
         tx_ready     = ($urandom_range(0, 3) == 0);
         rx_valid     = 1'($urandom_range(0, 1));
         rx_data      = 8'($urandom);
         @(negedge clk);
      end
      req_valid = 0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Responder end of the CPU's M-stage data-memory request interface: the same store-enable/ST_Size/LD_Size encodings the pipeline controller issues.
- Decodes the memory-mapped IO window and answers loads one cycle later with size-extended data. Performs stores.
- Owns a TX byte FIFO toward the UART, an RX byte handoff, and cycle/instruction counters.
- Sits beside the data cache; the datapath muxes rsp_rdata when rsp_hit is high.

Parameters:
- MMIO_BASE, 32'h8000_0000, base of the 256-byte MMIO window; addr[31:8] must match MMIO_BASE[31:8].
- TX_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- TX_AW, 2, log2(TX_DEPTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  M-stage access this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, unshifted
- req_st_size  in  2  0 = byte, 1 = half, 2 = word
- req_ld_size  in  3  FNC_LB/LH/LW/LBU/LHU encoding
- inst_retired  in  1  one instruction committed this cycle
- rsp_valid  out  1  load response valid
- rsp_hit  out  1  response belongs to the MMIO window
- rsp_rdata  out  32  extended load data
- tx_valid  out  1  FIFO head valid toward the UART
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  UART accepts the head byte
- rx_valid  in  1  UART holds a received byte
- rx_data  in  8  received byte
- rx_ready  out  1  pop pulse to the UART

Behaviour:
- Register map, by offset addr[7:0]:
  - 0x00 STATUS (RO): bit0 = TX not full, bit1 = rx_valid, other bits 0.
  - 0x04 RXDATA (RO): {24'b0, rx_data}.
  - 0x08 TXDATA (WO): pushes wdata[7:0].
  - 0x10 CYCLE (RO).
  - 0x14 INSTR (RO).
  - 0x18 CNTCLR (WO): any store clears both counters.
  - Unmapped offsets read 0; stores to them are ignored.
- Access qualification: an access counts only when req_valid is high and the window matches. Stores act at the clock edge with no response.
- Load timing: a load at edge N yields rsp_valid=1, rsp_hit=1 and rsp_rdata during cycle N+1. Both flags are 0 otherwise. A non-MMIO load gives rsp_valid=0.
- Load extension: the selected byte or half is chosen by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend. LW ignores addr[1:0]. An unknown ld_size behaves as LW.
- Store sizing: TXDATA always takes wdata[7:0], for any size. CNTCLR accepts any size.
- RX pop: an RXDATA load with rx_valid=1 pulses rx_ready for exactly one cycle, the cycle after the load edge. The returned byte is captured at the load edge. With rx_valid=0 the load returns 0 and there is no pulse.
- TX FIFO:
  - tx_valid = !empty; tx_data = head byte.
  - The head pops on tx_valid && tx_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - A push when full with no simultaneous pop is dropped. FIFO state is unchanged.
  - Pointers wrap modulo TX_DEPTH.
- Counters: 32-bit, wrap 0xFFFF_FFFF to 0.
  - CYCLE increments every cycle.
  - INSTR increments when inst_retired=1.
  - A CNTCLR store sets both to 0 at that edge. Clear wins over a same-cycle increment.
- Reset (async assert, sync release): rsp_valid=0, rsp_hit=0, rsp_rdata=0, rx_ready=0, tx_valid=0, tx_data=0, FIFO empty, counters 0.
- Reset mid-operation: an in-flight load response and all queued TX bytes are discarded.

Optional Feature:
- MMIO_TX_DROP_CNT_EN defined:
  - Adds TXDROP (RO) at offset 0x1C, a 32-bit count of dropped TX pushes, saturating at 0xFFFF_FFFF.
  - Cleared by CNTCLR and by reset.
- MMIO_TX_DROP_CNT_EN undefined: offset 0x1C reads 0 and no counter logic exists.

Decomposition:
- Shared header const.vh:
  - Offset constants MMIO_STATUS/RXDATA/TXDATA/CYCLE/INSTR/CNTCLR/TXDROP.
  - ST_SIZE_B/H/W encodings.
- FNC_LB etc. come from Opcode.vh.
- One sub-module: mmio_tx_fifo (parameters TX_DEPTH and TX_AW; push/pop/full/empty with a head-data output).

Test Plan:
- Counters: after reset hold 10 idle cycles, then LW 0x8000_0010 -> rsp_rdata=10 next cycle. Pulse inst_retired 3 times, then LW 0x8000_0014 -> 3. SW 0x8000_0018 at the same edge the counters would increment -> both read 0 (CYCLE then counts from 0).
- Loads: rx_valid=1, rx_data=0xA5.
  - LB 0x8000_0004 -> 0xFFFF_FFA5 and one rx_ready pulse.
  - With rx_valid=0, LBU -> 0 and no pulse.
- TX full and drop: tx_ready=0, SB 0x41,0x42,0x43,0x44,0x45 to 0x8000_0008 -> STATUS bit0=0 after the 4th. Raise tx_ready -> bytes 0x41..0x44 appear in order and 0x45 never does. With MMIO_TX_DROP_CNT_EN, TXDROP=1.
- Simultaneous: FIFO full, tx_ready=1 and a push in the same cycle -> push accepted, count stays 4, no drop.
- Async reset: with 3 bytes queued and a load in flight, assert reset_n=0 mid-cycle -> tx_valid and rsp_valid drop immediately. After release, STATUS reads 0x1 (rx_valid=0).
- Window miss: LW 0x1000_0010 -> rsp_valid=0. SW 0x1000_0008 -> FIFO is unchanged.
